// File: rtl/key_conditioner_pkg.sv
// Shared types and defaults for the pushbutton conditioner and its synchronizer.
package key_cond_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        HELD       = 2'd2,
        REL_WAIT   = 2'd3
    } key_state_t;

    localparam int DEFAULT_SYNC_STAGES    = 2;
    localparam int DEFAULT_DEBOUNCE_SIM   = 4;
    localparam int DEFAULT_DEBOUNCE_BOARD = 500000;

    // The debounced level is high whenever the key is accepted as held.
    function automatic logic state_is_held(key_state_t st);
        return (st == HELD) || (st == REL_WAIT);
    endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Pin-side key input and conditioned outputs of one player key.
interface key_conditioner_if;

    logic key_n;
    logic level;
    logic press;
    logic release_p;

    modport master (
        output key_n,
        input  level,
        input  press,
        input  release_p
    );

    modport slave (
        input  key_n,
        output level,
        output press,
        output release_p
    );

endinterface

// File: rtl/key_conditioner_sync.sv
// Multi-flop synchronizer for asynchronous board inputs; resets to 0.
module synchronizer
    import key_cond_pkg::*;
#(
    parameter int STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/key_conditioner.sv
// Pushbutton conditioner: synchronizer plus debounce FSM (enabled by KEY_DEBOUNCE_EN),
// producing a held level and single-cycle press / release pulses.
//
// state      | meaning
// IDLE       | released, level 0
// PRESS_WAIT | counting stable pressed samples, level 0
// HELD       | pressed, level 1
// REL_WAIT   | counting stable released samples, level 1
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_SIM,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic            clk,
    input  logic            reset,
    key_conditioner_if.slave key_if
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || CNT_W < 1) begin : g_bad_cfg
        $error("key_conditioner: SYNC_STAGES and DEBOUNCE_CYCLES must both be >= 2");
    end

    logic k_raw;
    logic s;

    assign k_raw = ~key_if.key_n;

    synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (k_raw),
        .q     (s)
    );

    logic level_q;
    logic level_d;
    logic press_q;
    logic press_d;
    logic release_q;
    logic release_d;

`ifdef KEY_DEBOUNCE_EN

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    key_state_t       state_q;
    key_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The sample that enters a WAIT state counts as the first stable one.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                cnt_d = '0;
                if (!s) begin
                    state_d = REL_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            REL_WAIT: begin
                if (s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        level_d = state_is_held(state_d);
    end

`else

    // Without debounce every edge of the synchronized input is reported.
    always_comb begin
        level_d   = s;
        press_d   = s & ~level_q;
        release_d = ~s & level_q;
    end

`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_if.level     = level_q;
    assign key_if.press     = press_q;
    assign key_if.release_p = release_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner; expectations follow whether KEY_DEBOUNCE_EN is defined.
module tb_key_conditioner;

`ifdef KEY_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif

    logic clk;
    logic reset;

    int checks;
    int failures;
    int press_seen;
    int rel_seen;
    int both_seen;

    logic [15:0] bp_press, bp_level, bp_rel;
    logic [15:0] rg_press, rg_level, rg_rel;
    logic [15:0] pg_press, pg_level, pg_rel;

    key_conditioner_if kif ();

    key_conditioner dut (
        .clk    (clk),
        .reset  (reset),
        .key_if (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (kif.press === 1'b1) press_seen++;
        if (kif.release_p === 1'b1) rel_seen++;
        if (kif.press === 1'b1 && kif.release_p === 1'b1) both_seen++;
    endtask

    task automatic check_outs(input string tag, input int e, input logic ep, input logic el, input logic er);
        check_val($sformatf("%s press e%0d", tag, e), {31'd0, kif.press}, {31'd0, ep});
        check_val($sformatf("%s level e%0d", tag, e), {31'd0, kif.level}, {31'd0, el});
        check_val($sformatf("%s release e%0d", tag, e), {31'd0, kif.release_p}, {31'd0, er});
    endtask

    task automatic idle(input int n);
        kif.key_n = 1'b1;
        repeat (n) tick();
    endtask

    task automatic run_release(input string tag);
        kif.key_n = 1'b1;
        for (int e = 1; e <= LAT + 3; e++) begin
            tick();
            check_outs(tag, e, 1'b0, (e < LAT), (e == LAT));
        end
    endtask

    task automatic run_post_reset(input string tag);
        for (int r = 1; r <= LAT + 3; r++) begin
            tick();
            check_outs(tag, r, (r == LAT), (r >= LAT), 1'b0);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        press_seen = 0;
        rel_seen   = 0;
        both_seen  = 0;

`ifdef KEY_DEBOUNCE_EN
        bp_press = 16'h0200; bp_level = 16'hFE00; bp_rel = 16'h0000;
        rg_press = 16'h0000; rg_level = 16'hFFFF; rg_rel = 16'h0000;
        pg_press = 16'h0000; pg_level = 16'h0000; pg_rel = 16'h0000;
`else
        bp_press = 16'h0048; bp_level = 16'hFFD8; bp_rel = 16'h0020;
        rg_press = 16'h0010; rg_level = 16'hFFF7; rg_rel = 16'h0008;
        pg_press = 16'h0008; pg_level = 16'h0008; pg_rel = 16'h0010;
`endif

        reset     = 1'b1;
        kif.key_n = 1'b1;
        tick();
        check_outs("reset", 1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        idle(3);

        press_seen = 0;
        rel_seen   = 0;
        kif.key_n  = 1'b0;
        for (int e = 1; e <= 100; e++) begin
            tick();
            check_outs("hold", e, (e == LAT), (e >= LAT), 1'b0);
        end
        check_val("hold press count", press_seen, 1);
        check_val("hold release count", rel_seen, 0);
        run_release("hold_rel");
        check_val("release count", rel_seen, 1);
        check_val("press count after release", press_seen, 1);
        idle(4);

        for (int e = 1; e <= 15; e++) begin
            kif.key_n = (e == 3);
            tick();
            check_outs("bounce", e, bp_press[e], bp_level[e], bp_rel[e]);
        end

        for (int e = 1; e <= 10; e++) begin
            kif.key_n = (e == 1);
            tick();
            check_outs("rel_glitch", e, rg_press[e], rg_level[e], rg_rel[e]);
        end
        run_release("bounce_rel");
        idle(4);

        for (int e = 1; e <= 10; e++) begin
            kif.key_n = (e != 1);
            tick();
            check_outs("press_glitch", e, pg_press[e], pg_level[e], pg_rel[e]);
        end
        idle(4);

        kif.key_n = 1'b0;
        repeat (10) tick();
        check_val("pre_reset level", {31'd0, kif.level}, 32'd1);
        reset = 1'b1;
        tick();
        check_outs("mid_hold_reset", 0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        run_post_reset("after_reset");
        run_release("after_reset_rel");
        idle(4);

        kif.key_n = 1'b0;
        repeat (LAT - 1) tick();
        reset = 1'b1;
        tick();
        check_outs("reset_on_accept", LAT, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        run_post_reset("after_wait_reset");
        run_release("final_rel");

        check_val("press and release together", both_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
